// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file.
package regfile_pkg;
  localparam int XZR_IDX        = 31;
  localparam int DEFAULT_WIDTH  = 64;
  localparam int DEFAULT_ADDR_W = 5;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_wr_decoder.sv
// Enable-gated index-to-one-hot decoder; the hardwired-zero register never gets a bit.
module regfile_wr_decoder #(
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic                 en,
  input  logic [ADDR_W-1:0]    idx,
  output logic [2**ADDR_W-1:0] onehot
);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  always_comb begin
    onehot = '0;
    if (en && (idx != ZERO_IDX)) onehot[idx] = 1'b1;
  end
endmodule

// File: rtl/regfile_param.sv
// Multi-read-port register file with optional write-through bypass and busy scoreboard.
// ID marks destinations busy via IssueValid; WB writes results and retires busy via RegWrite.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = XZR_IDX,
  parameter int BYPASS   = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_READ-1:0][ADDR_W-1:0]  ReadRegister,
  output logic [NUM_READ-1:0][WIDTH-1:0]   ReadData,
  output logic [NUM_READ-1:0]              ReadBusy,
  input  logic [ADDR_W-1:0]                WriteRegister,
  input  logic [WIDTH-1:0]                 WriteData,
  input  logic                             RegWrite,
  input  logic                             IssueValid,
  input  logic [ADDR_W-1:0]                IssueRegister,
  output logic                             AnyBusy
);
  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] wr_onehot, set_onehot;

  regfile_wr_decoder #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_wr_dec (
    .en     (RegWrite),
    .idx    (WriteRegister),
    .onehot (wr_onehot)
  );

  regfile_wr_decoder #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_set_dec (
    .en     (IssueValid),
    .idx    (IssueRegister),
    .onehot (set_onehot)
  );

  // Set is OR'd after the clear so a new producer supersedes the retiring one.
  // The write one-hot doubles as the clear vector: the zero register is never busy anyway.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_onehot[i]) regs_d[i] = WriteData;
    end
    busy_d = (busy_q & ~wr_onehot) | set_onehot;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_read
    logic wr_hit;
    assign wr_hit = (BYPASS != 0) && RegWrite && (WriteRegister == ReadRegister[p]);

    assign ReadData[p] = (ReadRegister[p] == ZERO_IDX) ? '0 :
                         wr_hit                        ? WriteData :
                                                         regs_q[ReadRegister[p]];
    assign ReadBusy[p] = busy_q[ReadRegister[p]] && !wr_hit;
  end

  assign AnyBusy = |busy_q;
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: directed vector table on bypass/no-bypass twins, then
// randomized traffic on a 4-port, 16-entry instance against a behavioural model.
module tb_regfile_param;
  logic clk;
  int   n_checks;
  int   n_errors;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shared stimulus for the BYPASS=1 (a) and BYPASS=0 (b) default-size instances
  logic                 rst;
  logic                 rw;
  logic [4:0]           wr;
  logic [63:0]          wd;
  logic                 iv;
  logic [4:0]           ir;
  logic [1:0][4:0]      rr;
  logic [1:0][63:0]     rd_a, rd_b;
  logic [1:0]           rb_a, rb_b;
  logic                 any_a, any_b;

  regfile_param #(.WIDTH(64), .ADDR_W(5), .NUM_READ(2), .ZERO_REG(31), .BYPASS(1)) dut_a (
    .clk(clk), .reset(rst), .ReadRegister(rr), .ReadData(rd_a), .ReadBusy(rb_a),
    .WriteRegister(wr), .WriteData(wd), .RegWrite(rw),
    .IssueValid(iv), .IssueRegister(ir), .AnyBusy(any_a)
  );

  regfile_param #(.WIDTH(64), .ADDR_W(5), .NUM_READ(2), .ZERO_REG(31), .BYPASS(0)) dut_b (
    .clk(clk), .reset(rst), .ReadRegister(rr), .ReadData(rd_b), .ReadBusy(rb_b),
    .WriteRegister(wr), .WriteData(wd), .RegWrite(rw),
    .IssueValid(iv), .IssueRegister(ir), .AnyBusy(any_b)
  );

  // 4 read ports, 16 entries, X15 hardwired to zero
  logic                 rst_c;
  logic                 rw_c;
  logic [3:0]           wr_c;
  logic [63:0]          wd_c;
  logic                 iv_c;
  logic [3:0]           ir_c;
  logic [3:0][3:0]      rr_c;
  logic [3:0][63:0]     rd_c;
  logic [3:0]           rb_c;
  logic                 any_c;

  regfile_param #(.WIDTH(64), .ADDR_W(4), .NUM_READ(4), .ZERO_REG(15), .BYPASS(1)) dut_c (
    .clk(clk), .reset(rst_c), .ReadRegister(rr_c), .ReadData(rd_c), .ReadBusy(rb_c),
    .WriteRegister(wr_c), .WriteData(wd_c), .RegWrite(rw_c),
    .IssueValid(iv_c), .IssueRegister(ir_c), .AnyBusy(any_c)
  );

  // ---------------- scoreboard helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_ab(input logic r, input logic w, input logic [4:0] wi, input logic [63:0] d,
                          input logic i, input logic [4:0] ii, input logic [4:0] r0, input logic [4:0] r1);
    rst = r; rw = w; wr = wi; wd = d; iv = i; ir = ii; rr[0] = r0; rr[1] = r1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst, rw;
    logic [4:0]  wr;
    logic [63:0] wd;
    logic        iv;
    logic [4:0]  ir, rr0, rr1;
    logic [63:0] a_d0, a_d1;
    logic        a_b0, a_b1, any;
    logic [63:0] b_d0, b_d1;
    logic        b_b0, b_b1;
  } vec_t;

  localparam logic [63:0] Z   = 64'h0;
  localparam logic [63:0] D11 = 64'h1111;
  localparam logic [63:0] D22 = 64'h2222;
  localparam logic [63:0] D99 = 64'h99;
  localparam logic [63:0] DB  = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] DF  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] DA  = 64'hABC;
  localparam logic [63:0] D44 = 64'h44;
  localparam logic [63:0] D45 = 64'h45;
  localparam logic [63:0] D55 = 64'h55;

  localparam int NV = 21;
  vec_t tbl [NV];

  // reference model for dut_c
  logic [63:0] m_regs [16];
  logic        m_busy [16];

  initial begin
    n_checks = 0;
    n_errors = 0;
    drive_ab(1'b1, 1'b0, 5'd0, Z, 1'b0, 5'd0, 5'd0, 5'd0);
    rst_c = 1'b1; rw_c = 1'b0; wr_c = '0; wd_c = '0; iv_c = 1'b0; ir_c = '0; rr_c = '0;

    //         rst   rw    wr     wd   iv    ir     rr0    rr1    a_d0 a_d1 ab0   ab1   any   b_d0 b_d1 bb0   bb1
    tbl[0]  = '{1'b0,1'b1,5'd5, D11,1'b0,5'd0, 5'd5, 5'd3, D11, Z,  1'b0,1'b0,1'b0, Z,   Z,  1'b0,1'b0};
    tbl[1]  = '{1'b0,1'b1,5'd3, D22,1'b1,5'd6, 5'd5, 5'd3, D11, D22,1'b0,1'b0,1'b0, D11, Z,  1'b0,1'b0};
    tbl[2]  = '{1'b1,1'b1,5'd5, D99,1'b0,5'd0, 5'd5, 5'd6, D99, Z,  1'b0,1'b1,1'b1, D11, Z,  1'b0,1'b1};
    tbl[3]  = '{1'b0,1'b0,5'd0, Z,  1'b0,5'd0, 5'd5, 5'd3, Z,   Z,  1'b0,1'b0,1'b0, Z,   Z,  1'b0,1'b0};
    tbl[4]  = '{1'b0,1'b0,5'd0, Z,  1'b0,5'd0, 5'd6, 5'd31,Z,   Z,  1'b0,1'b0,1'b0, Z,   Z,  1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b1,5'd3, DB, 1'b0,5'd0, 5'd0, 5'd1, Z,   Z,  1'b0,1'b0,1'b0, Z,   Z,  1'b0,1'b0};
    tbl[6]  = '{1'b0,1'b1,5'd31,DF, 1'b0,5'd0, 5'd3, 5'd3, DB,  DB, 1'b0,1'b0,1'b0, DB,  DB, 1'b0,1'b0};
    tbl[7]  = '{1'b0,1'b1,5'd31,DF, 1'b0,5'd0, 5'd31,5'd3, Z,   DB, 1'b0,1'b0,1'b0, Z,   DB, 1'b0,1'b0};
    tbl[8]  = '{1'b0,1'b0,5'd0, Z,  1'b0,5'd0, 5'd31,5'd31,Z,   Z,  1'b0,1'b0,1'b0, Z,   Z,  1'b0,1'b0};
    tbl[9]  = '{1'b0,1'b0,5'd0, Z,  1'b1,5'd9, 5'd9, 5'd9, Z,   Z,  1'b0,1'b0,1'b0, Z,   Z,  1'b0,1'b0};
    tbl[10] = '{1'b0,1'b0,5'd0, Z,  1'b0,5'd0, 5'd9, 5'd3, Z,   DB, 1'b1,1'b0,1'b1, Z,   DB, 1'b1,1'b0};
    tbl[11] = '{1'b0,1'b1,5'd9, DA, 1'b0,5'd0, 5'd9, 5'd9, DA,  DA, 1'b0,1'b0,1'b1, Z,   Z,  1'b1,1'b1};
    tbl[12] = '{1'b0,1'b0,5'd0, Z,  1'b0,5'd0, 5'd9, 5'd9, DA,  DA, 1'b0,1'b0,1'b0, DA,  DA, 1'b0,1'b0};
    tbl[13] = '{1'b0,1'b0,5'd0, Z,  1'b1,5'd4, 5'd4, 5'd9, Z,   DA, 1'b0,1'b0,1'b0, Z,   DA, 1'b0,1'b0};
    tbl[14] = '{1'b0,1'b1,5'd4, D44,1'b1,5'd4, 5'd4, 5'd9, D44, DA, 1'b0,1'b0,1'b1, Z,   DA, 1'b1,1'b0};
    tbl[15] = '{1'b0,1'b0,5'd0, Z,  1'b0,5'd0, 5'd4, 5'd9, D44, DA, 1'b1,1'b0,1'b1, D44, DA, 1'b1,1'b0};
    tbl[16] = '{1'b0,1'b1,5'd4, D45,1'b0,5'd0, 5'd4, 5'd9, D45, DA, 1'b0,1'b0,1'b1, D44, DA, 1'b1,1'b0};
    tbl[17] = '{1'b0,1'b0,5'd0, Z,  1'b1,5'd31,5'd4, 5'd31,D45, Z,  1'b0,1'b0,1'b0, D45, Z,  1'b0,1'b0};
    tbl[18] = '{1'b0,1'b0,5'd0, Z,  1'b0,5'd0, 5'd31,5'd4, Z,   D45,1'b0,1'b0,1'b0, Z,   D45,1'b0,1'b0};
    tbl[19] = '{1'b0,1'b1,5'd7, D55,1'b0,5'd0, 5'd7, 5'd4, D55, D45,1'b0,1'b0,1'b0, Z,   D45,1'b0,1'b0};
    tbl[20] = '{1'b0,1'b0,5'd0, Z,  1'b0,5'd0, 5'd7, 5'd4, D55, D45,1'b0,1'b0,1'b0, D55, D45,1'b0,1'b0};

    repeat (2) @(posedge clk);

    // ---------------- directed table ----------------
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      drive_ab(tbl[i].rst, tbl[i].rw, tbl[i].wr, tbl[i].wd, tbl[i].iv, tbl[i].ir, tbl[i].rr0, tbl[i].rr1);
      @(negedge clk);
      check($sformatf("v%0d a_data0", i), rd_a[0], tbl[i].a_d0);
      check($sformatf("v%0d a_data1", i), rd_a[1], tbl[i].a_d1);
      check($sformatf("v%0d a_busy0", i), 64'(rb_a[0]), 64'(tbl[i].a_b0));
      check($sformatf("v%0d a_busy1", i), 64'(rb_a[1]), 64'(tbl[i].a_b1));
      check($sformatf("v%0d a_any", i),   64'(any_a), 64'(tbl[i].any));
      check($sformatf("v%0d b_data0", i), rd_b[0], tbl[i].b_d0);
      check($sformatf("v%0d b_data1", i), rd_b[1], tbl[i].b_d1);
      check($sformatf("v%0d b_busy0", i), 64'(rb_b[0]), 64'(tbl[i].b_b0));
      check($sformatf("v%0d b_busy1", i), 64'(rb_b[1]), 64'(tbl[i].b_b1));
      check($sformatf("v%0d b_any", i),   64'(any_b), 64'(tbl[i].any));
    end

    // ---------------- multi-cycle: several busy bits wiped by reset ----------------
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      drive_ab(1'b0, 1'b0, 5'd0, Z, 1'b1, 5'(k), 5'd2, 5'd3);
    end
    @(posedge clk); #1;
    drive_ab(1'b0, 1'b0, 5'd0, Z, 1'b0, 5'd0, 5'd2, 5'd3);
    @(negedge clk);
    check("multi busy_x2", 64'(rb_a[0]), 64'd1);
    check("multi busy_x3", 64'(rb_a[1]), 64'd1);
    check("multi any_set", 64'(any_a), 64'd1);
    @(posedge clk); #1;
    drive_ab(1'b1, 1'b0, 5'd0, Z, 1'b1, 5'd8, 5'd2, 5'd8);
    @(posedge clk); #1;
    drive_ab(1'b0, 1'b0, 5'd0, Z, 1'b0, 5'd0, 5'd2, 5'd8);
    @(negedge clk);
    check("multi busy_after_rst", 64'(rb_a[0]), 64'd0);
    check("multi issue_in_rst",   64'(rb_a[1]), 64'd0);
    check("multi any_after_rst",  64'(any_a), 64'd0);

    // ---------------- randomized traffic vs behavioural model ----------------
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    @(posedge clk); #1;
    rst_c = 1'b1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(posedge clk); #1;
      rst_c = ($urandom_range(0, 199) == 0);
      rw_c  = 1'($urandom_range(0, 1));
      wr_c  = 4'($urandom_range(0, 15));
      wd_c  = {$urandom, $urandom};
      iv_c  = ($urandom_range(0, 2) == 0);
      ir_c  = 4'($urandom_range(0, 15));
      for (int p = 0; p < 4; p++) rr_c[p] = 4'($urandom_range(0, 15));
      @(negedge clk);
      begin
        logic [63:0] exp_d;
        logic        exp_b;
        logic        exp_any;
        logic        retiring;
        for (int p = 0; p < 4; p++) begin
          retiring = rw_c && (wr_c == rr_c[p]);
          if (rr_c[p] == 4'd15) exp_d = '0;
          else if (retiring)    exp_d = wd_c;
          else                  exp_d = m_regs[rr_c[p]];
          exp_b = m_busy[rr_c[p]] && !retiring;
          check($sformatf("rnd%0d data%0d", cyc, p), rd_c[p], exp_d);
          check($sformatf("rnd%0d busy%0d", cyc, p), 64'(rb_c[p]), 64'(exp_b));
        end
        exp_any = 1'b0;
        for (int i = 0; i < 16; i++) exp_any = exp_any | m_busy[i];
        check($sformatf("rnd%0d any", cyc), 64'(any_c), 64'(exp_any));
      end
      // state after the coming edge
      if (rst_c) begin
        for (int i = 0; i < 16; i++) begin
          m_regs[i] = '0;
          m_busy[i] = 1'b0;
        end
      end else begin
        if (rw_c && wr_c != 4'd15) m_regs[wr_c] = wd_c;
        if (rw_c) m_busy[wr_c] = 1'b0;
        if (iv_c && ir_c != 4'd15) m_busy[ir_c] = 1'b1;
      end
    end

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
